// File: rtl/nic_link_out_arbiter.sv
// -----------------------------------------------------------------------------
// nic_link_out_arbiter
//
// Output-link stage of a NIC. Each cycle it picks at most one flit from the
// per-VC output queues in round-robin order and registers it onto the link
// toward the peer NIC. It also keeps a credit count for each downstream VC
// buffer. A packet head is only sent when the peer reports that VC buffer as
// free; body and tail flits only need a credit.
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   flit_i           head flit of each queue, VC v at [v*FLIT_WIDTH +: FLIT_WIDTH]
//   flit_valid_i     queue v has a flit at its head
//   flit_tail_i      head flit of queue v is a packet tail
//   flit_pop_o       one-hot dequeue strobe (combinational)
//   out_link_o       flit toward the peer NIC (registered)
//   is_valid_o       out_link_o carries a flit this cycle (registered)
//   credit_signal_i  per-VC pulse: one downstream slot was freed
//   free_signal_i    per-VC level: downstream VC buffer is empty
//   credit_err_o     sticky: a credit arrived while that counter was already full
//
// Per-VC packet state
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   PKT_IDLE | next flit from this VC is a head; it needs free_signal_i
//   PKT_BODY | a packet is partly sent; body/tail need only a credit
// -----------------------------------------------------------------------------
module nic_link_out_arbiter #(
    parameter int N_TOT_OF_VC  = 4,
    parameter int FLIT_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 4,
    parameter int CNT_W        = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_TOT_OF_VC*FLIT_WIDTH-1:0] flit_i,
    input  logic [N_TOT_OF_VC-1:0]            flit_valid_i,
    input  logic [N_TOT_OF_VC-1:0]            flit_tail_i,
    output logic [N_TOT_OF_VC-1:0]            flit_pop_o,
    output logic [FLIT_WIDTH-1:0]             out_link_o,
    output logic                              is_valid_o,
    input  logic [N_TOT_OF_VC-1:0]            credit_signal_i,
    input  logic [N_TOT_OF_VC-1:0]            free_signal_i,
    output logic                              credit_err_o
);

    localparam int               PTR_W       = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1;
    localparam logic [CNT_W-1:0] CREDIT_INIT = CNT_W'(BUFFER_DEPTH);
    localparam logic [PTR_W-1:0] LAST_VC     = PTR_W'(N_TOT_OF_VC - 1);

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_t;

    pkt_state_t             pkt_state [N_TOT_OF_VC];
    logic [CNT_W-1:0]       credit    [N_TOT_OF_VC];
    logic [PTR_W-1:0]       rr_ptr;

    logic [N_TOT_OF_VC-1:0] eligible;
    logic                   grant_any;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       rr_next;
    logic [FLIT_WIDTH-1:0]  flit_arr  [N_TOT_OF_VC];

    // Unpack the flat flit bus so the winner can be selected by index.
    always_comb begin
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            flit_arr[v] = flit_i[v*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    // A head waits for the downstream buffer to be free; once a packet is
    // under way the remaining flits are limited by credits only.
    always_comb begin
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            eligible[v] = flit_valid_i[v]
                        & (credit[v] != '0)
                        & ((pkt_state[v] == PKT_BODY) | free_signal_i[v]);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping past the last VC.
    always_comb begin : rr_search
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < N_TOT_OF_VC; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_TOT_OF_VC) begin
                cand = cand - N_TOT_OF_VC;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_any && eligible[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign rr_next = (grant_idx == LAST_VC) ? '0 : grant_idx + 1'b1;

    // The pop is gated by rst so the upstream queues keep their flits while
    // the link stage is being reset.
    always_comb begin
        flit_pop_o = '0;
        if (!rst && grant_any) begin
            flit_pop_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            is_valid_o   <= 1'b0;
            out_link_o   <= '0;
            credit_err_o <= 1'b0;
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                credit[v]    <= CREDIT_INIT;
                pkt_state[v] <= PKT_IDLE;
            end
        end else begin
            if (grant_any) begin
                out_link_o <= flit_arr[grant_idx];
                is_valid_o <= 1'b1;
                rr_ptr     <= rr_next;
            end else begin
                is_valid_o <= 1'b0;
            end

            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                // A send and a returned credit in the same cycle cancel out.
                // A credit into a full counter is a peer protocol error: the
                // count saturates and the error flag latches.
                case ({flit_pop_o[v], credit_signal_i[v]})
                    2'b10: credit[v] <= credit[v] - 1'b1;
                    2'b01: begin
                        if (credit[v] == CREDIT_INIT) begin
                            credit_err_o <= 1'b1;
                        end else begin
                            credit[v] <= credit[v] + 1'b1;
                        end
                    end
                    default: ;
                endcase

                // Single-flit packets (head is also tail) leave the VC idle.
                if (flit_pop_o[v]) begin
                    pkt_state[v] <= flit_tail_i[v] ? PKT_IDLE : PKT_BODY;
                end
            end
        end
    end

endmodule

// File: tb/tb_nic_link_out_arbiter.sv
module tb_nic_link_out_arbiter;

    localparam int N  = 4;
    localparam int FW = 64;
    localparam int BD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*FW-1:0]   flit_i;
    logic [N-1:0]      flit_valid_i;
    logic [N-1:0]      flit_tail_i;
    logic [N-1:0]      flit_pop_o;
    logic [FW-1:0]     out_link_o;
    logic              is_valid_o;
    logic [N-1:0]      credit_signal_i;
    logic [N-1:0]      free_signal_i;
    logic              credit_err_o;

    nic_link_out_arbiter #(
        .N_TOT_OF_VC (N),
        .FLIT_WIDTH  (FW),
        .BUFFER_DEPTH(BD),
        .CNT_W       (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_i         (flit_i),
        .flit_valid_i   (flit_valid_i),
        .flit_tail_i    (flit_tail_i),
        .flit_pop_o     (flit_pop_o),
        .out_link_o     (out_link_o),
        .is_valid_o     (is_valid_o),
        .credit_signal_i(credit_signal_i),
        .free_signal_i  (free_signal_i),
        .credit_err_o   (credit_err_o)
    );

    always #5 clk = ~clk;

    // Upstream queues and downstream controls owned by the bench.
    logic [FW-1:0] q_data [N][$];
    bit            q_tail [N][$];
    bit [N-1:0]    free_v;
    bit [N-1:0]    pulse_v;

    // Reference model state.
    int            credit_m [N];
    bit            in_pkt_m [N];
    int            rr_m;
    bit            valid_m;
    logic [FW-1:0] link_m;
    bit            err_m;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input int v, input int p, input int i);
        return (64'(v) << 56) | (64'(p) << 8) | 64'(i);
    endfunction

    // Winner = eligible VC with the smallest forward distance from rr_m.
    function automatic int pick();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        for (int v = 0; v < N; v++) begin
            if (q_data[v].size() != 0 && credit_m[v] > 0 && (in_pkt_m[v] || free_v[v])) begin
                d = (v - rr_m + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = v;
                end
            end
        end
        return best;
    endfunction

    task automatic push_pkt(input int v, input int p, input int len);
        for (int i = 0; i < len; i++) begin
            q_data[v].push_back(mk(v, p, i));
            q_tail[v].push_back(i == len - 1);
        end
    endtask

    task automatic push_rand(input int v);
        int len;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            q_data[v].push_back({$urandom, $urandom});
            q_tail[v].push_back(i == len - 1);
        end
    endtask

    task automatic drive_inputs();
        for (int v = 0; v < N; v++) begin
            flit_valid_i[v]        = (q_data[v].size() != 0);
            flit_i[v*FW +: FW]     = (q_data[v].size() != 0) ? q_data[v][0] : '0;
            flit_tail_i[v]         = (q_data[v].size() != 0) ? q_tail[v][0] : 1'b0;
        end
        free_signal_i   = free_v;
        credit_signal_i = pulse_v;
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            for (int v = 0; v < N; v++) begin
                credit_m[v] = BD;
                in_pkt_m[v] = 1'b0;
            end
            rr_m    = 0;
            valid_m = 1'b0;
            link_m  = '0;
            err_m   = 1'b0;
        end else begin
            w = pick();
            for (int v = 0; v < N; v++) begin
                if (v == w && !pulse_v[v]) begin
                    credit_m[v] = credit_m[v] - 1;
                end else if (v != w && pulse_v[v]) begin
                    if (credit_m[v] == BD) err_m = 1'b1;
                    else credit_m[v] = credit_m[v] + 1;
                end
            end
            if (w >= 0) begin
                link_m      = q_data[w][0];
                valid_m     = 1'b1;
                rr_m        = (w + 1) % N;
                in_pkt_m[w] = !q_tail[w][0];
                void'(q_data[w].pop_front());
                void'(q_tail[w].pop_front());
            end else begin
                valid_m = 1'b0;
            end
        end
    endtask

    task automatic tick();
        drive_inputs();
        @(posedge clk);
        #1;
        model_step();
        pulse_v = '0;
        drive_inputs();
    endtask

    task automatic restore_credits();
        bit any;
        for (int k = 0; k < 2 * BD; k++) begin
            any = 1'b0;
            for (int v = 0; v < N; v++) begin
                pulse_v[v] = (credit_m[v] < BD);
                if (credit_m[v] < BD) any = 1'b1;
            end
            if (!any) break;
            tick();
        end
        pulse_v = '0;
    endtask

    // Compare process: every cycle, mid-period, against the model.
    always @(negedge clk) begin
        if (chk_en) begin : cmp
            logic [N-1:0] exp_pop;
            int           w;
            exp_pop = '0;
            if (!rst) begin
                w = pick();
                if (w >= 0) exp_pop[w] = 1'b1;
            end
            check("pop", 64'(flit_pop_o), 64'(exp_pop));
            check("valid", 64'(is_valid_o), 64'(valid_m));
            check("link", out_link_o, link_m);
            check("err", 64'(credit_err_o), 64'(err_m));
        end
    end

    initial begin : stim
        int sent;
        rst     = 1'b1;
        free_v  = '1;
        pulse_v = '0;
        for (int v = 0; v < N; v++) begin
            credit_m[v] = BD;
            in_pkt_m[v] = 1'b0;
        end
        rr_m = 0; valid_m = 1'b0; link_m = '0; err_m = 1'b0;

        // Reset with every VC offering a flit.
        for (int v = 0; v < N; v++) push_pkt(v, 1, 1);
        tick();
        chk_en = 1'b1;
        #1;
        check("rst_pop", 64'(flit_pop_o), 64'(0));
        tick();
        check("rst_valid", 64'(is_valid_o), 64'(0));
        check("rst_link", out_link_o, 64'(0));
        rst = 1'b0;

        // Round robin over four single-flit packets, then VC1 + VC3.
        for (int v = 0; v < N; v++) begin
            tick();
            check("rr_order", out_link_o, mk(v, 1, 0));
            check("rr_valid", 64'(is_valid_o), 64'(1));
        end
        tick();
        check("idle_valid", 64'(is_valid_o), 64'(0));
        push_pkt(1, 2, 1);
        push_pkt(3, 2, 1);
        tick();
        check("rr_vc1", out_link_o, mk(1, 2, 0));
        tick();
        check("rr_vc3", out_link_o, mk(3, 2, 0));

        // VC1 at credit 2: send plus return in one cycle keeps it at 2.
        push_pkt(1, 3, 1);
        pulse_v[1] = 1'b1;
        tick();
        check("send_pulse_link", out_link_o, mk(1, 3, 0));
        push_pkt(1, 4, 3);
        sent = 0;
        repeat (3) begin
            tick();
            sent += int'(is_valid_o);
        end
        check("vc1_credit_2", 64'(sent), 64'(2));
        pulse_v[1] = 1'b1;
        tick();
        check("pulse_cycle_idle", 64'(is_valid_o), 64'(0));
        tick();
        check("vc1_tail", out_link_o, mk(1, 4, 2));
        check("vc1_tail_valid", 64'(is_valid_o), 64'(1));
        restore_credits();

        // Credit exhaustion on a 5-flit packet.
        push_pkt(0, 5, 5);
        sent = 0;
        repeat (6) begin
            tick();
            sent += int'(is_valid_o);
        end
        check("vc0_4_of_5", 64'(sent), 64'(4));
        check("vc0_held_link", out_link_o, mk(0, 5, 3));
        pulse_v[0] = 1'b1;
        tick();
        check("vc0_pulse_idle", 64'(is_valid_o), 64'(0));
        tick();
        check("vc0_tail", out_link_o, mk(0, 5, 4));
        check("vc0_tail_valid", 64'(is_valid_o), 64'(1));
        restore_credits();

        // Head gating by free_signal_i.
        free_v    = '1;
        free_v[2] = 1'b0;
        push_pkt(2, 6, 3);
        repeat (5) begin
            drive_inputs();
            #1;
            check("gated_pop", 64'(flit_pop_o), 64'(0));
            tick();
            check("gated_valid", 64'(is_valid_o), 64'(0));
        end
        free_v[2] = 1'b1;
        drive_inputs();
        #1;
        check("head_pop", 64'(flit_pop_o), 64'(4'b0100));
        tick();
        check("head_link", out_link_o, mk(2, 6, 0));
        free_v[2] = 1'b0;
        tick();
        check("body_nofree", out_link_o, mk(2, 6, 1));
        tick();
        check("tail_nofree", out_link_o, mk(2, 6, 2));
        check("tail_nofree_v", 64'(is_valid_o), 64'(1));
        free_v = '1;
        restore_credits();

        // Reset mid-packet: the next VC0 flit is treated as a head.
        push_pkt(0, 7, 3);
        tick();
        check("pre_rst_head", out_link_o, mk(0, 7, 0));
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(is_valid_o), 64'(0));
        rst = 1'b0;
        free_v[0] = 1'b0;
        drive_inputs();
        #1;
        check("post_rst_gated", 64'(flit_pop_o), 64'(0));
        tick();
        check("post_rst_valid", 64'(is_valid_o), 64'(0));
        free_v[0] = 1'b1;
        drive_inputs();
        #1;
        check("post_rst_pop", 64'(flit_pop_o), 64'(4'b0001));
        tick();
        check("post_rst_link", out_link_o, mk(0, 7, 1));
        tick();
        check("post_rst_tail", out_link_o, mk(0, 7, 2));

        // Randomized traffic; credits are only returned for flits in flight.
        for (int c = 0; c < 3000; c++) begin
            for (int v = 0; v < N; v++) begin
                if (q_data[v].size() < 6 && $urandom_range(0, 3) == 0) push_rand(v);
                free_v[v]  = ($urandom_range(0, 9) < 7);
                pulse_v[v] = (credit_m[v] < BD) && ($urandom_range(0, 2) == 0);
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        for (int v = 0; v < N; v++) begin
            q_data[v].delete();
            q_tail[v].delete();
        end
        free_v = '1;
        tick();
        restore_credits();
        check("no_err_yet", 64'(credit_err_o), 64'(0));

        // Credit pulse into a full counter latches the error.
        pulse_v[2] = 1'b1;
        tick();
        check("err_set", 64'(credit_err_o), 64'(1));
        repeat (3) tick();
        check("err_sticky", 64'(credit_err_o), 64'(1));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
